tone_sequencer: RTL and testbench

- Upstream driver for the tone-select stage: produces the 3-bit tone code (Do=000 … Do2=111) and a tone enable that the divider-select/frequency-divider path consumes.
- Two modes:
  - Idle/manual: forwards the manual tone selection.
  - Sequence: plays a fixed 8-note melody from an internal ROM with per-note durations and inter-note gaps.
- Supports start, stop and loop control.

---
 rtl/tone_sequencer.sv | 140 ++++++++++++++
 tb/tb_tone_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// tone_sequencer: forwards the manual tone in IDLE or plays an 8-note ROM melody with gaps, stop and loop
module tone_sequencer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 2500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic [2:0] manual_tone,
    input  logic       manual_en,
    output logic [2:0] tone_sel,
    output logic       tone_en,
    output logic       busy,
    output logic [2:0] note_idx,
    output logic       done
);
    localparam int CW = BEAT_CYCLES > 1 ? $clog2(BEAT_CYCLES) : 1;
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    // beats-1 per note, note 7 in the top slice
    localparam logic [15:0] BEATS_M1 = {2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        r_state, w_state;
    logic [CW-1:0] r_cyc, w_cyc;
    logic [1:0]    r_beat, w_beat;
    logic [GW-1:0] r_gap, w_gap;
    logic [2:0]    r_idx, w_idx, r_sel, w_sel;
    logic          r_en, w_en, r_busy, w_busy, r_done, w_done;
    logic [1:0]    w_beat_last;
    logic          w_cyc_wrap, w_note_end;
    logic [2:0]    w_next;

    assign w_beat_last = BEATS_M1[{r_idx, 1'b0} +: 2];
    assign w_cyc_wrap  = r_cyc == CYC_LAST;
    assign w_note_end  = w_cyc_wrap && r_beat == w_beat_last;
    assign w_next      = r_idx + 3'd1;

    always_comb begin
        w_state = r_state;
        w_cyc   = r_cyc;
        w_beat  = r_beat;
        w_gap   = r_gap;
        w_idx   = r_idx;
        w_sel   = r_sel;
        w_en    = r_en;
        w_busy  = r_busy;
        w_done  = 1'b0;
        if (r_state != IDLE && stop) begin
            w_state = IDLE;
            w_en    = 1'b0;
            w_busy  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_sel  = manual_tone;
                    w_en   = manual_en;
                    w_busy = 1'b0;
                    if (start && !stop) begin
                        w_state = PLAY;
                        w_idx   = '0;
                        w_sel   = '0;
                        w_en    = 1'b1;
                        w_busy  = 1'b1;
                        w_cyc   = '0;
                        w_beat  = '0;
                    end
                end
                PLAY: begin
                    w_cyc  = w_cyc_wrap ? '0 : r_cyc + 1'b1;
                    w_beat = w_cyc_wrap ? r_beat + 1'b1 : r_beat;
                    if (w_note_end) begin
                        if (r_idx == 3'd7 && !loop) begin
                            w_state = IDLE;
                            w_done  = 1'b1;
                            w_en    = 1'b0;
                            w_busy  = 1'b0;
                        end else if (GAP_CYCLES > 0) begin
                            w_state = GAP;
                            w_en    = 1'b0;
                            w_gap   = '0;
                        end else begin
                            w_idx  = w_next;
                            w_sel  = w_next;
                            w_cyc  = '0;
                            w_beat = '0;
                        end
                    end
                end
                GAP: begin
                    if (r_gap == GAP_LAST) begin
                        w_state = PLAY;
                        w_idx   = w_next;
                        w_sel   = w_next;
                        w_en    = 1'b1;
                        w_cyc   = '0;
                        w_beat  = '0;
                    end else begin
                        w_gap = r_gap + 1'b1;
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cyc   <= '0;
            r_beat  <= '0;
            r_gap   <= '0;
            r_idx   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cyc   <= w_cyc;
            r_beat  <= w_beat;
            r_gap   <= w_gap;
            r_idx   <= w_idx;
            r_sel   <= w_sel;
            r_en    <= w_en;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    assign tone_sel = r_sel;
    assign tone_en  = r_en;
    assign busy     = r_busy;
    assign note_idx = r_idx;
    assign done     = r_done;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: table vectors, melody timing sequences and a random run against a timeline model
module tb_tone_sequencer;
    localparam int B = 4;

    typedef struct {
        bit         rst;
        bit         st;
        bit         sp;
        logic [2:0] mt;
        bit         me;
        logic [2:0] e_sel;
        bit         e_en;
        bit         e_busy;
        logic [2:0] e_idx;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0, manual_en = 1'b0;
    logic [2:0] manual_tone = 3'd0;
    logic [2:0] o_sel [2];
    logic [2:0] o_idx [2];
    logic       o_en [2];
    logic       o_busy [2];
    logic       o_done [2];

    int errors = 0, checks = 0;
    bit m_busy [2];
    bit m_en [2];
    bit m_done [2];
    int m_t [2];
    int m_sel [2];
    int m_idx [2];

    vec_t tbl [9];
    bit   a_en [75];
    bit   a_done [75];
    bit   a_busy [75];
    int   a_sel [75];
    int   a_idx [75];
    bit   a_en1 [75];
    bit   a_done1 [75];
    bit   l_en0 [200];
    bit   l_en1 [200];
    bit   l_done0 [200];
    bit   l_done1 [200];
    int   l_idx0 [200];
    int   l_idx1 [200];
    int   l_sel0 [200];

    always #5 clk = ~clk;

    tone_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .manual_tone(manual_tone), .manual_en(manual_en),
        .tone_sel(o_sel[0]), .tone_en(o_en[0]), .busy(o_busy[0]), .note_idx(o_idx[0]), .done(o_done[0])
    );

    tone_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .manual_tone(manual_tone), .manual_en(manual_en),
        .tone_sel(o_sel[1]), .tone_en(o_en[1]), .busy(o_busy[1]), .note_idx(o_idx[1]), .done(o_done[1])
    );

    function automatic int beats(input int i);
        return i == 7 ? 4 : i == 6 ? 3 : (i == 2 || i == 3) ? 2 : 1;
    endfunction

    function automatic int gap_of(input int k);
        return k == 0 ? 2 : 0;
    endfunction

    // position t cycles into a pass -> current note and whether it is sounding
    task automatic decode(input int t, input int g, output int n, output bit play);
        int r;
        r = t;
        n = 7;
        play = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (r < beats(i) * B) begin
                n = i;
                play = 1'b1;
                return;
            end
            r -= beats(i) * B;
            if (r < g) begin
                n = i;
                play = 1'b0;
                return;
            end
            r -= g;
        end
    endtask

    task automatic model_step();
        int n, t, g;
        bit p;
        for (int k = 0; k < 2; k++) begin
            g = gap_of(k);
            if (reset) begin
                m_busy[k] = 1'b0; m_en[k] = 1'b0; m_done[k] = 1'b0; m_sel[k] = 0; m_idx[k] = 0;
            end else if (!m_busy[k]) begin
                m_done[k] = 1'b0;
                if (start && !stop) begin
                    m_busy[k] = 1'b1; m_t[k] = 0; m_idx[k] = 0; m_sel[k] = 0; m_en[k] = 1'b1;
                end else begin
                    m_sel[k] = int'(manual_tone); m_en[k] = manual_en;
                end
            end else if (stop) begin
                m_busy[k] = 1'b0; m_en[k] = 1'b0; m_done[k] = 1'b0;
            end else begin
                t = m_t[k] + 1;
                m_done[k] = 1'b0;
                if (t == 15 * B + 7 * g && !loop) begin
                    m_busy[k] = 1'b0; m_done[k] = 1'b1; m_en[k] = 1'b0;
                end else begin
                    if (t >= 15 * B + 8 * g) t = 0;
                    decode(t, g, n, p);
                    m_idx[k] = n; m_sel[k] = n; m_en[k] = p;
                end
                m_t[k] = t;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("model u%0d tone_sel", k), int'(o_sel[k]), m_sel[k]);
            chk($sformatf("model u%0d tone_en", k), int'(o_en[k]), int'(m_en[k]));
            chk($sformatf("model u%0d busy", k), int'(o_busy[k]), int'(m_busy[k]));
            chk($sformatf("model u%0d note_idx", k), int'(o_idx[k]), m_idx[k]);
            chk($sformatf("model u%0d done", k), int'(o_done[k]), int'(m_done[k]));
        end
    endtask

    initial begin
        int len, p1, p2, q1, q2, cnt;
        bit found;
        int hi [$];
        int lo [$];
        int rs [$];
        tbl[0] = '{1, 0, 0, 3'b101, 1, 3'b000, 0, 0, 3'd0};
        tbl[1] = '{1, 1, 0, 3'b101, 1, 3'b000, 0, 0, 3'd0};
        tbl[2] = '{0, 0, 0, 3'b101, 1, 3'b101, 1, 0, 3'd0};
        tbl[3] = '{0, 0, 0, 3'b010, 0, 3'b010, 0, 0, 3'd0};
        tbl[4] = '{0, 1, 1, 3'b011, 1, 3'b011, 1, 0, 3'd0};
        tbl[5] = '{0, 0, 1, 3'b110, 1, 3'b110, 1, 0, 3'd0};
        tbl[6] = '{0, 1, 0, 3'b111, 1, 3'b000, 1, 1, 3'd0};
        tbl[7] = '{0, 0, 0, 3'b111, 0, 3'b000, 1, 1, 3'd0};
        tbl[8] = '{1, 0, 0, 3'b100, 1, 3'b000, 0, 0, 3'd0};
        tick();
        for (int i = 0; i < 9; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; stop = tbl[i].sp;
            manual_tone = tbl[i].mt; manual_en = tbl[i].me;
            tick();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("vec%0d u%0d tone_sel", i, k), int'(o_sel[k]), int'(tbl[i].e_sel));
                chk($sformatf("vec%0d u%0d tone_en", i, k), int'(o_en[k]), int'(tbl[i].e_en));
                chk($sformatf("vec%0d u%0d busy", i, k), int'(o_busy[k]), int'(tbl[i].e_busy));
                chk($sformatf("vec%0d u%0d note_idx", i, k), int'(o_idx[k]), int'(tbl[i].e_idx));
                chk($sformatf("vec%0d u%0d done", i, k), int'(o_done[k]), 0);
            end
        end

        // full pass with start held high throughout
        reset = 1'b0; stop = 1'b0; loop = 1'b0; start = 1'b1; manual_en = 1'b0;
        tick();
        for (int c = 0; c < 75; c++) begin
            a_en[c] = o_en[0]; a_done[c] = o_done[0]; a_busy[c] = o_busy[0];
            a_sel[c] = int'(o_sel[0]); a_idx[c] = int'(o_idx[0]);
            a_en1[c] = o_en[1]; a_done1[c] = o_done[1];
            if (c < 74) tick();
        end
        start = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        len = 1;
        for (int c = 1; c < 75; c++) begin
            if (c == 74 || a_en[c] != a_en[c-1]) begin
                if (a_en[c-1]) begin
                    hi.push_back(len);
                    rs.push_back(a_sel[c-1]);
                end else begin
                    lo.push_back(len);
                end
                len = 1;
            end else begin
                len++;
            end
        end
        chk("pass tone runs", hi.size(), 8);
        chk("pass gap runs", lo.size(), 7);
        for (int i = 0; i < hi.size() && i < 8; i++) begin
            chk($sformatf("pass note%0d length", i), hi[i], beats(i) * B);
            chk($sformatf("pass note%0d tone_sel", i), rs[i], i);
        end
        foreach (lo[i]) chk($sformatf("pass gap%0d length", i), lo[i], 2);
        cnt = 0;
        for (int c = 0; c < 74; c++) cnt += int'(a_done[c]);
        chk("pass early done", cnt, 0);
        chk("pass done at 74", int'(a_done[74]), 1);
        chk("pass busy before end", int'(a_busy[73]), 1);
        chk("pass busy falls", int'(a_busy[74]), 0);
        chk("pass idx holds 7", a_idx[74], 7);
        cnt = 0;
        for (int c = 0; c < 60; c++) cnt += int'(a_en1[c]);
        chk("nogap continuous tone", cnt, 60);
        cnt = 0;
        for (int c = 0; c < 60; c++) cnt += int'(a_done1[c]);
        chk("nogap early done", cnt, 0);
        chk("nogap done at 60", int'(a_done1[60]), 1);
        chk("nogap tone off at done", int'(a_en1[60]), 0);

        // looping playback
        loop = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            l_en0[c] = o_en[0]; l_en1[c] = o_en[1]; l_done0[c] = o_done[0]; l_done1[c] = o_done[1];
            l_idx0[c] = int'(o_idx[0]); l_idx1[c] = int'(o_idx[1]); l_sel0[c] = int'(o_sel[0]);
            tick();
        end
        p1 = -1; p2 = -1; q1 = -1; q2 = -1; cnt = 0;
        for (int c = 1; c < 200; c++) begin
            if (l_en0[c] && !l_en0[c-1] && l_idx0[c] == 0) begin
                if (p1 < 0) p1 = c; else if (p2 < 0) p2 = c;
            end
            if (l_idx1[c] == 0 && l_idx1[c-1] == 7) begin
                if (q1 < 0) q1 = c; else if (q2 < 0) q2 = c;
            end
        end
        for (int c = 0; c < 200; c++) cnt += int'(l_done0[c]) + int'(l_done1[c]);
        chk("loop no done", cnt, 0);
        chk("loop first wrap", p1, 76);
        chk("loop second wrap", p2, 152);
        chk("loop gap after note7", int'(l_en0[74]) + int'(l_en0[75]), 0);
        chk("loop gap idx", l_idx0[75], 7);
        if (p1 >= 0) chk("loop wrap tone_sel", l_sel0[p1], 0);
        chk("nogap loop first wrap", q1, 60);
        chk("nogap loop second wrap", q2, 120);
        cnt = 0;
        for (int c = 0; c < 200; c++) cnt += int'(l_en1[c]);
        chk("nogap loop continuous", cnt, 200);
        loop = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;

        // stop during note 3
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 100 && !found; w++) begin
            if (o_idx[0] == 3'd3 && o_en[0]) found = 1'b1;
            else tick();
        end
        chk("reach note 3", int'(found), 1);
        stop = 1'b1; manual_tone = 3'b101; manual_en = 1'b1;
        tick();
        chk("stop tone_en", int'(o_en[0]), 0);
        chk("stop busy", int'(o_busy[0]), 0);
        chk("stop done", int'(o_done[0]), 0);
        chk("stop nogap busy", int'(o_busy[1]), 0);
        stop = 1'b0;
        tick();
        chk("after stop tone_sel", int'(o_sel[0]), 5);
        chk("after stop tone_en", int'(o_en[0]), 1);

        // reset while in a gap
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int w = 0; w < 50 && !found; w++) begin
            if (o_busy[0] && !o_en[0]) found = 1'b1;
            else tick();
        end
        chk("reach gap", int'(found), 1);
        reset = 1'b1;
        tick();
        chk("gap reset tone_sel", int'(o_sel[0]), 0);
        chk("gap reset tone_en", int'(o_en[0]), 0);
        chk("gap reset busy", int'(o_busy[0]), 0);
        chk("gap reset note_idx", int'(o_idx[0]), 0);
        chk("gap reset done", int'(o_done[0]), 0);
        reset = 1'b0;

        // random run against the timeline model
        for (int c = 0; c < 15000; c++) begin
            reset = $urandom_range(0, 499) == 0;
            stop = $urandom_range(0, 199) == 0;
            start = $urandom_range(0, 29) == 0;
            if ($urandom_range(0, 99) == 0) loop = ~loop;
            manual_tone = 3'($urandom);
            manual_en = 1'($urandom);
            tick();
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
